// File: rtl/sca_trig_pkg.sv
// Shared definitions for the side-channel trigger generator: modes, channel
// state encoding, default counter width and the arming-event selector.
package sca_trig_pkg;

    localparam int CNT_W_DEF = 16;

    localparam logic [1:0] MODE_OFF         = 2'd0;
    localparam logic [1:0] MODE_PULSE_START = 2'd1;
    localparam logic [1:0] MODE_LEVEL       = 2'd2;
    localparam logic [1:0] MODE_PULSE_END   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    // Start-armed modes listen to ev_start, PULSE_END to ev_end, OFF to nothing.
    function automatic logic arm_event(input logic [1:0] mode,
                                       input logic       ev_start,
                                       input logic       ev_end);
        case (mode)
            MODE_PULSE_START,
            MODE_LEVEL:       return ev_start;
            MODE_PULSE_END:   return ev_end;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sca_trig_ch.sv
// One trigger channel: config registers, IDLE/DELAY/ACTIVE FSM with a
// down-counter, registered trigger outputs and the sticky overrun flag.
module sca_trig_ch
    import sca_trig_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic             ev_start,
    input  logic             ev_end,
    output logic             trig,
    output logic             trign,
    output logic             busy,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] width_eff;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e           state_q, state_d;
    logic             trig_d, ovf_d;
    logic             arm, free, fin;

    always_comb begin
        // NOTE: every value written here is defaulted first, so no latch can be inferred.
        mode_d    = we ? cfg_mode  : mode_q;
        delay_d   = we ? cfg_delay : delay_q;
        width_d   = we ? cfg_width : width_q;
        width_eff = (width_d == '0) ? ONE : width_d;
        arm       = arm_event(mode_d, ev_start, ev_end);
        state_d   = state_q;
        cnt_d     = cnt_q;
        trig_d    = trig;
        ovf_d     = ovf;
        free      = 1'b0;
        fin       = 1'b0;

        if (we) begin
            // A config write cancels any activity; an idle channel may still arm on it.
            ovf_d = 1'b0;
            if (state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                trig_d  = 1'b0;
            end else begin
                free = 1'b1;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: free = 1'b1;
                ST_DELAY: begin
                    if (mode_q == MODE_LEVEL && ev_end) begin
                        state_d = ST_IDLE;
                        free    = 1'b1;
                    end else begin
                        ovf_d = ovf | arm;
                        if (cnt_q == ONE) begin
                            state_d = ST_ACTIVE;
                            trig_d  = 1'b1;
                            cnt_d   = width_eff;
                        end else begin
                            cnt_d = cnt_q - ONE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    fin = (mode_q == MODE_LEVEL) ? ev_end : (cnt_q == ONE);
                    if (fin) begin
                        state_d = ST_IDLE;
                        trig_d  = 1'b0;
                        free    = 1'b1;
                    end else begin
                        ovf_d = ovf | arm;
                        if (mode_q != MODE_LEVEL) cnt_d = cnt_q - ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // The edge a channel becomes free counts as idle, so back-to-back events re-arm.
        if (free && arm) begin
            if (delay_d == '0) begin
                state_d = ST_ACTIVE;
                trig_d  = 1'b1;
                cnt_d   = width_eff;
            end else begin
                state_d = ST_DELAY;
                trig_d  = 1'b0;
                cnt_d   = delay_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; every flop, config included, clears on rst.
        if (rst) begin
            mode_q  <= MODE_OFF;
            delay_q <= '0;
            width_q <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            trig    <= 1'b0;
            trign   <= 1'b1;
            busy    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            delay_q <= delay_d;
            width_q <= width_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            trig    <= trig_d;
            trign   <= ~trig_d;
            busy    <= (state_d != ST_IDLE);
            ovf     <= ovf_d;
        end
    end

endmodule

// File: rtl/sca_trig_gen.sv
// Multi-channel trigger generator: decodes the config write to one channel
// and fans the cipher handshake events out to NCH independent channels.
module sca_trig_gen
    import sca_trig_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int CNT_W = CNT_W_DEF,
    parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic             ev_start,
    input  logic             ev_end,
    output logic [NCH-1:0]   trig,
    output logic [NCH-1:0]   trign,
    output logic [NCH-1:0]   busy,
    output logic [NCH-1:0]   ovf
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        // Addresses at or above NCH match no channel and are dropped here.
        logic we_i;
        assign we_i = cfg_we && (cfg_ch == CH_W'(i));

        sca_trig_ch #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .we        (we_i),
            .cfg_mode  (cfg_mode),
            .cfg_delay (cfg_delay),
            .cfg_width (cfg_width),
            .ev_start  (ev_start),
            .ev_end    (ev_end),
            .trig      (trig[i]),
            .trign     (trign[i]),
            .busy      (busy[i]),
            .ovf       (ovf[i])
        );
    end

endmodule

// File: tb/tb_sca_trig_gen.sv
// Self-checking bench for sca_trig_gen: time-based reference model compared
// every cycle, directed pattern checks with literal expectations, random traffic.
module tb_sca_trig_gen;
    import sca_trig_pkg::*;

    localparam int NCH   = 3;
    localparam int CNT_W = 8;
    localparam int CH_W  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_mode;
    logic [CNT_W-1:0] cfg_delay;
    logic [CNT_W-1:0] cfg_width;
    logic             ev_start;
    logic             ev_end;
    logic [NCH-1:0]   trig, trign, busy, ovf;

    always #5 clk = ~clk;

    sca_trig_gen #(.NCH(NCH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width), .ev_start(ev_start), .ev_end(ev_end),
        .trig(trig), .trign(trign), .busy(busy), .ovf(ovf)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each armed channel is a scheduled window [rise, fall) in edge numbers.
    int  m_mode[NCH], m_delay[NCH], m_width[NCH], m_rise[NCH], m_fall[NCH];
    bit  m_act[NCH], m_ovf[NCH];
    bit  m_valid = 1'b0;
    int  edge_n = 0;
    logic [NCH-1:0] exp_trig = '0, exp_busy = '0, exp_ovf = '0;

    function automatic bit arms(input int mode, input logic s, input logic e);
        if (mode == 1 || mode == 2) return s;
        if (mode == 3) return e;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        edge_n++;
        if (rst) m_valid = 1'b1;
        for (int ch = 0; ch < NCH; ch++) begin
            bit we, arm, free, fin;
            if (rst) begin
                m_mode[ch] = 0; m_delay[ch] = 0; m_width[ch] = 0;
                m_act[ch] = 1'b0; m_ovf[ch] = 1'b0;
            end else begin
                we = cfg_we && (int'(cfg_ch) == ch);
                if (we) begin
                    m_mode[ch]  = int'(cfg_mode);
                    m_delay[ch] = int'(cfg_delay);
                    m_width[ch] = int'(cfg_width);
                    m_ovf[ch]   = 1'b0;
                end
                arm = arms(m_mode[ch], ev_start, ev_end);
                if (we) begin
                    free = !m_act[ch];
                    m_act[ch] = 1'b0;
                end else if (!m_act[ch]) begin
                    free = 1'b1;
                end else begin
                    fin = (m_mode[ch] == 2) ? ev_end : (edge_n == m_fall[ch]);
                    if (fin) begin
                        m_act[ch] = 1'b0;
                        free = 1'b1;
                    end else begin
                        free = 1'b0;
                        if (arm) m_ovf[ch] = 1'b1;
                    end
                end
                if (free && arm) begin
                    m_act[ch]  = 1'b1;
                    m_rise[ch] = edge_n + m_delay[ch];
                    m_fall[ch] = m_rise[ch] + ((m_width[ch] == 0) ? 1 : m_width[ch]);
                end
            end
            exp_trig[ch] = m_act[ch] && (edge_n >= m_rise[ch]);
            exp_busy[ch] = m_act[ch];
            exp_ovf[ch]  = m_ovf[ch];
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_trig",  32'(trig),  32'(exp_trig));
            check("cyc_trign", 32'(trign), {{(32-NCH){1'b0}}, ~exp_trig});
            check("cyc_busy",  32'(busy),  32'(exp_busy));
            check("cyc_ovf",   32'(ovf),   32'(exp_ovf));
        end
    end

    logic [NCH-1:0] trig_log[32], busy_log[32], trign_log[32];

    function automatic logic [31:0] bits_of(input int sel, input int ch);
        logic [31:0] v = '0;
        for (int k = 0; k < 32; k++)
            v[k] = (sel == 0) ? trig_log[k][ch] : (sel == 1) ? busy_log[k][ch] : trign_log[k][ch];
        return v;
    endfunction

    task automatic cfg_write(input int ch, input int mode, input int d, input int w);
        @(negedge clk);
        cfg_ch = CH_W'(ch); cfg_mode = 2'(mode); cfg_delay = CNT_W'(d); cfg_width = CNT_W'(w);
        cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Index k of each pattern is sampled at edge t+k; log[k] holds outputs after edge t+k.
    task automatic seq(input logic [31:0] sp, input logic [31:0] ep, input logic [31:0] wp,
                       input logic [31:0] rp, input int n);
        for (int k = 0; k < 32; k++) begin
            trig_log[k] = '0; busy_log[k] = '0; trign_log[k] = '1;
        end
        @(negedge clk);
        ev_start = sp[0]; ev_end = ep[0]; cfg_we = wp[0]; rst = rp[0];
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            trig_log[k] = trig; busy_log[k] = busy; trign_log[k] = trign;
            ev_start = sp[k+1]; ev_end = ep[k+1]; cfg_we = wp[k+1]; rst = rp[k+1];
        end
        ev_start = 1'b0; ev_end = 1'b0; cfg_we = 1'b0; rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int first, ones;
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_delay = '0; cfg_width = '0;
        ev_start = 1'b0; ev_end = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_trig",  32'(trig),  32'h0);
        check("reset_trign", 32'(trign), 32'h7);
        check("reset_busy",  32'(busy),  32'h0);
        check("reset_ovf",   32'(ovf),   32'h0);
        rst = 1'b0;

        cfg_write(0, 1, 5, 3);
        seq(32'h1, 32'h0, 32'h0, 32'h0, 12);
        check("t1_trig",  bits_of(0, 0), 32'h0E0);
        check("t1_trign", bits_of(2, 0) & 32'hFFF, 32'hF1F);
        check("t1_busy",  bits_of(1, 0), 32'h0FF);

        cfg_write(0, 1, 0, 0);
        seq(32'h1, 32'h0, 32'h0, 32'h0, 6);
        check("t2_trig", bits_of(0, 0), 32'h1);
        check("t2_busy", bits_of(1, 0), 32'h1);

        cfg_write(0, 2, 2, 0);
        seq(32'h1, 32'h1 << 10, 32'h0, 32'h0, 14);
        check("t3_level_trig", bits_of(0, 0), 32'h3FC);
        seq(32'h1, 32'h2, 32'h0, 32'h0, 8);
        check("t3_abort_trig", bits_of(0, 0), 32'h0);
        check("t3_abort_busy", bits_of(1, 0), 32'h1);

        cfg_write(0, 1, 4, 2);
        cfg_write(1, 3, 4, 2);
        seq(32'h1, 32'h1 << 20, 32'h0, 32'h0, 30);
        check("t4_ch0", bits_of(0, 0), 32'h30);
        check("t4_ch1", bits_of(0, 1), 32'h0300_0000);

        cfg_write(0, 1, 10, 4);
        seq(32'h9, 32'h0, 32'h0, 32'h0, 16);
        check("t5_trig", bits_of(0, 0), 32'h3C00);
        check("t5_ovf_set", 32'(ovf[0]), 32'h1);
        cfg_write(0, 1, 10, 4);
        check("t5_ovf_clr", 32'(ovf[0]), 32'h0);

        cfg_write(0, 1, 0, 2);
        seq(32'h5, 32'h0, 32'h0, 32'h0, 8);
        check("b2b_trig", bits_of(0, 0), 32'hF);
        check("b2b_ovf", 32'(ovf[0]), 32'h0);

        cfg_write(0, 0, 0, 0);
        cfg_ch = 2'd0; cfg_mode = 2'd1; cfg_delay = 8'd1; cfg_width = 8'd1;
        seq(32'h1, 32'h0, 32'h1, 32'h0, 6);
        check("we_arm_trig", bits_of(0, 0), 32'h2);

        cfg_write(0, 1, 6, 4);
        seq(32'h1, 32'h0, 32'h8, 32'h0, 14);
        check("t6_we_trig", bits_of(0, 0), 32'h0);
        check("t6_we_busy", bits_of(1, 0), 32'h7);

        cfg_write(0, 1, 1, 1);
        cfg_ch = 2'd3; cfg_mode = 2'd0; cfg_delay = 8'd0; cfg_width = 8'd0;
        seq(32'h1, 32'h0, 32'h1, 32'h0, 6);
        check("t6_badch_trig", bits_of(0, 0), 32'h2);

        cfg_write(0, 1, 2, 6);
        seq(32'h1, 32'h0, 32'h0, 32'h10, 12);
        check("t6_rst_trig", bits_of(0, 0), 32'hC);
        seq(32'h1, 32'h0, 32'h0, 32'h0, 8);
        check("t6_cfg_lost", bits_of(0, 0), 32'h0);

        cfg_write(0, 1, 255, 255);
        @(negedge clk); ev_start = 1'b1;
        @(negedge clk); ev_start = 1'b0;
        first = -1; ones = 0;
        for (int k = 0; k < 600; k++) begin
            if (trig[0]) begin
                ones++;
                if (first < 0) first = k;
            end
            @(negedge clk);
        end
        check("max_delay_rise", 32'(first), 32'd255);
        check("max_width_len",  32'(ones),  32'd255);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            ev_start = ($urandom_range(0, 3) == 0);
            ev_end   = ($urandom_range(0, 5) == 0);
            rst      = ($urandom_range(0, 399) == 0);
            cfg_we   = ($urandom_range(0, 29) == 0);
            cfg_ch   = CH_W'($urandom_range(0, 3));
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_delay = ($urandom_range(0, 19) == 0) ? 8'd255 : CNT_W'($urandom_range(0, 6));
            cfg_width = ($urandom_range(0, 19) == 0) ? 8'd255 : CNT_W'($urandom_range(0, 6));
        end
        @(negedge clk);
        ev_start = 1'b0; ev_end = 1'b0; rst = 1'b0; cfg_we = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
